// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - pixel, key and frame inputs plus game status outputs of game_ctrl
interface game_ctrl_if;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic        is_stickman;
    logic        is_obstacle;
    logic        playing;
    logic        game_over;
    logic [3:0]  speed;
    logic [15:0] score;
    logic [15:0] high_score;

    modport master (
        output frame_clk, keycode, is_stickman, is_obstacle,
        input  playing, game_over, speed, score, high_score
    );

    modport slave (
        input  frame_clk, keycode, is_stickman, is_obstacle,
        output playing, game_over, speed, score, high_score
    );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game state machine, per-frame collision detect, BCD score, high score and speed level
module game_ctrl #(
    parameter logic [7:0]  SCORE_DIV  = 8'd6,
    parameter logic [15:0] SPEED_STEP = 16'h0050,
    parameter logic [3:0]  SPEED_MIN  = 4'd2,
    parameter logic [3:0]  SPEED_MAX  = 4'd9,
    parameter logic [7:0]  KEY_START  = 8'h28
) (
    input logic       Clk,
    input logic       Reset,
    game_ctrl_if.slave ctl
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    logic [1:0]  state, state_n;
    logic        frame_dly, frame_tick;
    logic        hit_acc, hit_acc_n;
    logic        restart_armed, restart_armed_n;
    logic [7:0]  fcnt, fcnt_n;
    logic [15:0] score, score_n, score_inc;
    logic [15:0] high_score, high_score_n;
    logic [3:0]  speed, speed_n;
    logic        playing_r, game_over_r;
    logic        coincide, start_key, step_hit;

    // Saturating 4-digit BCD increment; 9999 stays put.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign coincide  = ctl.is_stickman & ctl.is_obstacle;
    assign start_key = (ctl.keycode == KEY_START);
    assign score_inc = bcd_inc(score);
    // Step detection looks at the two low BCD digits only, which covers steps of x50 and x100.
    assign step_hit  = (score_inc != score) && (score_inc != 16'h0000) &&
                       ((score_inc[7:0] == 8'h00) || (score_inc[7:0] == SPEED_STEP[7:0]));

    always_comb begin
        state_n         = state;
        hit_acc_n       = hit_acc;
        restart_armed_n = restart_armed;
        fcnt_n          = fcnt;
        score_n         = score;
        high_score_n    = high_score;
        speed_n         = speed;
        case (state)
            S_IDLE: begin
                if (start_key) begin
                    state_n   = S_PLAY;
                    score_n   = 16'h0000;
                    speed_n   = SPEED_MIN;
                    hit_acc_n = 1'b0;
                    fcnt_n    = 8'd0;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    hit_acc_n = 1'b0;
                    if (hit_acc | coincide) begin
                        state_n         = S_OVER;
                        restart_armed_n = 1'b0;
                        if (score > high_score)
                            high_score_n = score;
                    end else if (fcnt == SCORE_DIV - 8'd1) begin
                        fcnt_n  = 8'd0;
                        score_n = score_inc;
                        if (step_hit && speed < SPEED_MAX)
                            speed_n = speed + 4'd1;
                    end else begin
                        fcnt_n = fcnt + 8'd1;
                    end
                end else if (coincide) begin
                    hit_acc_n = 1'b1;
                end
            end
            S_OVER: begin
                // Enter must be seen released after the crash before it can restart.
                if (!start_key) begin
                    restart_armed_n = 1'b1;
                end else if (restart_armed) begin
                    state_n   = S_PLAY;
                    score_n   = 16'h0000;
                    speed_n   = SPEED_MIN;
                    hit_acc_n = 1'b0;
                    fcnt_n    = 8'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= S_IDLE;
            frame_dly     <= 1'b0;
            frame_tick    <= 1'b0;
            hit_acc       <= 1'b0;
            restart_armed <= 1'b0;
            fcnt          <= 8'd0;
            score         <= 16'h0000;
            high_score    <= 16'h0000;
            speed         <= SPEED_MIN;
            playing_r     <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            state         <= state_n;
            frame_dly     <= ctl.frame_clk;
            frame_tick    <= ctl.frame_clk & ~frame_dly;
            hit_acc       <= hit_acc_n;
            restart_armed <= restart_armed_n;
            fcnt          <= fcnt_n;
            score         <= score_n;
            high_score    <= high_score_n;
            speed         <= speed_n;
            playing_r     <= (state_n == S_PLAY);
            game_over_r   <= (state_n == S_OVER);
        end
    end

    assign ctl.playing    = playing_r;
    assign ctl.game_over  = game_over_r;
    assign ctl.speed      = speed;
    assign ctl.score      = score;
    assign ctl.high_score = high_score;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl (default instance plus a one-frame-per-point instance)
module tb_game_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #10 Clk = ~Clk;

    game_ctrl_if bus ();
    game_ctrl_if bus_f ();

    game_ctrl dut (.Clk(Clk), .Reset(Reset), .ctl(bus));
    game_ctrl #(.SCORE_DIV(8'd1)) dut_fast (.Clk(Clk), .Reset(Reset), .ctl(bus_f));

    typedef struct {
        bit          sel;
        logic        playing;
        logic        game_over;
        logic [3:0]  speed;
        logic [15:0] score;
        logic [15:0] high_score;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    int         m_score[2], m_hi[2], m_speed[2], m_fcnt[2];
    int         m_div[2] = '{6, 1};
    bit         m_play[2], m_over[2], m_hit[2], m_armed[2];
    logic [7:0] m_key[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic m_reset();
        for (int s = 0; s < 2; s++) begin
            m_score[s] = 0; m_hi[s] = 0; m_speed[s] = 2; m_fcnt[s] = 0;
            m_play[s] = 0; m_over[s] = 0; m_hit[s] = 0; m_armed[s] = 0;
            m_key[s] = 8'h00;
        end
    endtask

    task automatic m_start(input bit s);
        m_play[s] = 1; m_over[s] = 0; m_score[s] = 0; m_speed[s] = 2;
        m_hit[s] = 0; m_fcnt[s] = 0;
    endtask

    task automatic m_tick(input bit s, input bit co);
        if (m_play[s]) begin
            if (m_hit[s] || co) begin
                m_play[s] = 0; m_over[s] = 1; m_armed[s] = 0;
                if (m_score[s] > m_hi[s]) m_hi[s] = m_score[s];
            end else if (m_fcnt[s] == m_div[s] - 1) begin
                m_fcnt[s] = 0;
                if (m_score[s] < 9999) begin
                    m_score[s]++;
                    if (m_score[s] % 50 == 0 && m_speed[s] < 9) m_speed[s]++;
                end
            end else begin
                m_fcnt[s]++;
            end
            m_hit[s] = 0;
        end
    endtask

    task automatic sb_push(input bit s, input string tag);
        exp_t e;
        e.sel        = s;
        e.playing    = m_play[s];
        e.game_over  = m_over[s];
        e.speed      = 4'(m_speed[s]);
        e.score      = to_bcd(m_score[s]);
        e.high_score = to_bcd(m_hi[s]);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".playing"},    e.sel ? bus_f.playing    : bus.playing,    e.playing);
        check({t, ".game_over"},  e.sel ? bus_f.game_over  : bus.game_over,  e.game_over);
        check({t, ".speed"},      e.sel ? bus_f.speed      : bus.speed,      e.speed);
        check({t, ".score"},      e.sel ? bus_f.score      : bus.score,      e.score);
        check({t, ".high_score"}, e.sel ? bus_f.high_score : bus.high_score, e.high_score);
    endtask

    task automatic set_key(input bit s, input logic [7:0] k);
        if (s) bus_f.keycode = k; else bus.keycode = k;
        m_key[s] = k;
    endtask

    task automatic set_ov(input bit s, input logic v);
        if (s) begin bus_f.is_stickman = v; bus_f.is_obstacle = v; end
        else   begin bus.is_stickman = v;   bus.is_obstacle = v;   end
    endtask

    task automatic set_fc(input bit s, input logic v);
        if (s) bus_f.frame_clk = v; else bus.frame_clk = v;
    endtask

    // One frame: tick is live in the second cycle; co forces overlap in exactly that cycle.
    task automatic frame(input bit s, input bit co);
        set_fc(s, 1'b1);
        cyc(1);
        if (co) set_ov(s, 1'b1);
        cyc(1);
        set_ov(s, 1'b0);
        cyc(1);
        set_fc(s, 1'b0);
        cyc(1);
        m_tick(s, co);
        if (m_over[s] && m_key[s] != 8'h28) m_armed[s] = 1;
    endtask

    task automatic pulse_overlap(input bit s);
        set_ov(s, 1'b1);
        cyc(1);
        set_ov(s, 1'b0);
        cyc(1);
        if (m_play[s]) m_hit[s] = 1;
    endtask

    task automatic press(input bit s, input string tag);
        set_key(s, 8'h28);
        if ((!m_play[s] && !m_over[s]) || (m_over[s] && m_armed[s])) m_start(s);
        sb_push(s, tag);
        cyc(1);
        sb_pop();
        set_key(s, 8'h00);
        cyc(1);
        if (m_over[s]) m_armed[s] = 1;
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        m_reset();
        sb_push(0, {tag, ".main"});
        sb_push(1, {tag, ".fast"});
        cyc(1);
        sb_pop();
        sb_pop();
        Reset = 1'b0;
    endtask

    initial begin
        bus.frame_clk = 0; bus.keycode = 0; bus.is_stickman = 0; bus.is_obstacle = 0;
        bus_f.frame_clk = 0; bus_f.keycode = 0; bus_f.is_stickman = 0; bus_f.is_obstacle = 0;
        m_reset();
        cyc(2);
        do_reset("reset");

        set_key(0, 8'h29);
        cyc(2);
        set_key(0, 8'h00);
        pulse_overlap(0);
        sb_push(0, "idle_ignore");
        cyc(1);
        sb_pop();

        press(0, "start");
        for (int i = 1; i <= 600; i++) begin
            frame(0, 1'b0);
            if (i == 6 || i == 54 || i == 60 || i == 300 || i == 600) begin
                sb_push(0, $sformatf("frames%0d", i));
                sb_pop();
            end
        end

        pulse_overlap(0);
        cyc(3);
        sb_push(0, "hit_pending");
        sb_pop();
        frame(0, 1'b0);
        sb_push(0, "collide_mid");
        sb_pop();
        frame(0, 1'b0);
        sb_push(0, "frozen");
        sb_pop();

        press(0, "restart1");
        for (int i = 0; i < 6; i++) frame(0, 1'b0);
        set_key(0, 8'h28);
        frame(0, 1'b1);
        sb_push(0, "collide_on_tick");
        sb_pop();
        cyc(10);
        sb_push(0, "hold_enter");
        sb_pop();
        set_key(0, 8'h00);
        cyc(1);
        m_armed[0] = 1;
        press(0, "restart2");
        for (int i = 0; i < 6; i++) frame(0, 1'b0);
        sb_push(0, "game3");
        sb_pop();
        do_reset("reset_mid");

        press(1, "fast_start");
        for (int i = 1; i <= 10002; i++) begin
            frame(1, 1'b0);
            if (i == 9 || i == 10 || i == 50 || i == 100 || i == 350 || i == 400 ||
                i == 9999 || i == 10002) begin
                sb_push(1, $sformatf("fast%0d", i));
                sb_pop();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
